sseg_scan_decoder: RTL and testbench
====================================

// Module: sseg_scan_decoder
// PURPOSE
//  Receive-side counterpart of the multiplexed 7-segment display drive (an/sseg). Samples the
//  scanned anode/segment lines, rejects transition ghosting, decodes each digit's glyph back to a
//  4-bit code and assembles full 4-digit frames. Used as an on-chip display monitor and as the
//  checker the timer/stopwatch benches hang off the display outputs.
// PARAMETERS
//  STABLE_CYCLES   16         consecutive identical samples required before a digit is captured
//  TIMEOUT_CYCLES  2_000_000  clk cycles with no single active anode before scan_lost asserts
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-low reset
//  an           in   4   anode lines, active-low, an[0] = rightmost digit
//  sseg         in   8   segments, active-low; [0]=a .. [6]=g, [7]=dp
//  digits       out  16  decoded codes, digits[4i+3:4i] = digit i
//  dp           out  4   decimal point state per digit, 1 = lit
//  seg_err      out  4   per digit: last captured glyph not in decode table
//  frame_valid  out  1   1-cycle pulse: all 4 digits captured since previous pulse
//  scan_lost    out  1   level: no valid anode for TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset: digits=0, dp=0, seg_err=0, frame_valid=0, scan_lost=0, FSM=IDLE, counters=0, seen-mask=0.
//  Input sync: an, sseg each pass a 2-FF synchroniser; all logic below uses synchronised copies.
//  Valid anode = exactly one bit low; index i = position of that bit. 0 or >1 low = no anode.
//  FSM:
//   IDLE    : no valid anode. -> SETTLE on valid anode (load sample={i,sseg}, stab_cnt=1).
//   SETTLE  : if current {i,sseg} == sample: stab_cnt++; when stab_cnt reaches STABLE_CYCLES ->
//             capture, -> HOLD. If differs: reload sample, stab_cnt=1 (stay); if anode invalid -> IDLE.
//   HOLD    : stay while {i,sseg} unchanged; any change -> SETTLE (valid) or IDLE (invalid).
//  Capture (one cycle, registered on the SETTLE->HOLD edge): digits[i]=decode(sseg[6:0]),
//   dp[i]=~sseg[7], seg_err[i]=1 if glyph undecodable (digits[i] then 4'hF), seen[i]=1.
//   Other digits' registers untouched. Outputs update the cycle after the capture cycle.
//  Decode table (active-high abcdefg): 0..9 standard, A,b,C,d,E,F for 10..15; blank (all off)
//   decodes to 4'h0 with seg_err=1.
//  Frame: when a capture sets the last missing seen bit, frame_valid pulses the same cycle that
//   digits updates, and seen clears to 0. Recapture of an already-seen digit before frame
//   completes overwrites its value, no pulse. Capture of a new digit and seen-clear never overlap
//   (one capture per cycle max).
//  Latency: pin change to digits update = 2 (sync) + STABLE_CYCLES + 1 clk.
//  Timeout: idle_cnt counts cycles with no valid anode, clears on any valid anode; at
//   TIMEOUT_CYCLES scan_lost=1 and counter saturates; scan_lost clears the cycle after a
//   valid anode is seen. Timeout also clears seen (partial frame discarded); digits retained.
//  Glitch shorter than STABLE_CYCLES during HOLD forces re-settle but, if the original pattern
//   returns, recapture writes the identical value (no visible change, may complete a frame).
//  Reset mid-operation: immediate return to reset values, partial frame discarded.
//  Counter widths: $clog2(param+1); no wrap (stab_cnt stops at STABLE_CYCLES, idle_cnt saturates).
// TESTING
//  1 Scan "12.34" (an cycling 1110,1101,1011,0111, 100 clk each) -> digits=16'h1234, dp=4'b0100,
//    frame_valid pulses once per full scan, seg_err=0.
//  2 Hold an=1110 with sseg alternating every 8 clk (STABLE_CYCLES=16) -> no capture, no frame.
//  3 Drive an=1100 (two active) for 50 clk -> FSM IDLE, no capture; then legal scan resumes ok.
//  4 an=1111 for TIMEOUT_CYCLES (bench param 1000) -> scan_lost=1 at cycle 1000+2; first valid
//    anode clears it next cycle; seen mask restarted (frame needs all 4 digits again).
//  5 Digit 2 glyph 7'b1111111 active-high-off pattern invalid (e.g. segs a+d only) ->
//    seg_err[2]=1, digits[11:8]=4'hF; other digits decode normally.
//  6 Assert reset low mid-SETTLE and mid-frame -> all outputs 0 immediately, first frame_valid
//    only after 4 fresh captures post-release.

Source files
------------

// File: rtl/sseg_scan_decoder.sv
// Monitors a multiplexed 7-segment drive (an/sseg), filters scan ghosting and rebuilds the
// displayed 4-digit value, decimal points and per-digit glyph errors as whole frames.
module sseg_scan_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [7:0]  sseg,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  seg_err,
  output logic        frame_valid,
  output logic        scan_lost,
  output logic [1:0]  fsm_state
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2} state_t;

  state_t      state;
  logic [3:0]  an_s1, an_s2;
  logic [7:0]  sseg_s1, sseg_s2;
  logic        an_ok;
  logic [1:0]  an_idx;
  logic [9:0]  cur, sample;
  logic [SW-1:0] stab_cnt;
  logic [TW-1:0] idle_cnt;
  logic        cap_pend;
  logic [1:0]  cap_idx;
  logic [7:0]  cap_seg;
  logic [3:0]  seen, cap_bit;
  logic [4:0]  dec;
  logic        timeout_hit;

  // Returns {err, code}; glyph is active-high gfedcba.
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    case (g)
      7'h3F: decode_glyph = {1'b0, 4'h0};
      7'h06: decode_glyph = {1'b0, 4'h1};
      7'h5B: decode_glyph = {1'b0, 4'h2};
      7'h4F: decode_glyph = {1'b0, 4'h3};
      7'h66: decode_glyph = {1'b0, 4'h4};
      7'h6D: decode_glyph = {1'b0, 4'h5};
      7'h7D: decode_glyph = {1'b0, 4'h6};
      7'h07: decode_glyph = {1'b0, 4'h7};
      7'h7F: decode_glyph = {1'b0, 4'h8};
      7'h6F: decode_glyph = {1'b0, 4'h9};
      7'h77: decode_glyph = {1'b0, 4'hA};
      7'h7C: decode_glyph = {1'b0, 4'hB};
      7'h39: decode_glyph = {1'b0, 4'hC};
      7'h5E: decode_glyph = {1'b0, 4'hD};
      7'h79: decode_glyph = {1'b0, 4'hE};
      7'h71: decode_glyph = {1'b0, 4'hF};
      7'h00: decode_glyph = {1'b1, 4'h0};
      default: decode_glyph = {1'b1, 4'hF};
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_s1   <= 4'hF;
      an_s2   <= 4'hF;
      sseg_s1 <= 8'hFF;
      sseg_s2 <= 8'hFF;
    end else begin
      an_s1   <= an;
      an_s2   <= an_s1;
      sseg_s1 <= sseg;
      sseg_s2 <= sseg_s1;
    end
  end

  always_comb begin
    an_ok  = 1'b1;
    an_idx = 2'd0;
    case (an_s2)
      4'b1110: an_idx = 2'd0;
      4'b1101: an_idx = 2'd1;
      4'b1011: an_idx = 2'd2;
      4'b0111: an_idx = 2'd3;
      default: an_ok = 1'b0;
    endcase
  end

  assign cur         = {an_idx, sseg_s2};
  assign dec         = decode_glyph(~cap_seg[6:0]);
  assign cap_bit     = 4'b0001 << cap_idx;
  assign timeout_hit = !an_ok && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign fsm_state   = state;

  // Valid/ready is not used here: cap_pend is a one-cycle strobe carrying cap_idx/cap_seg,
  // and the output stage always accepts it on the following edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sample   <= '0;
      stab_cnt <= '0;
      cap_pend <= 1'b0;
      cap_idx  <= 2'd0;
      cap_seg  <= 8'h00;
    end else begin
      cap_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (an_ok) begin
            sample   <= cur;
            stab_cnt <= SW'(1);
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (!an_ok) begin
            stab_cnt <= '0;
            state    <= IDLE;
          end else if (cur != sample) begin
            sample   <= cur;
            stab_cnt <= SW'(1);
          end else if (stab_cnt >= SW'(STABLE_CYCLES - 1)) begin
            stab_cnt <= SW'(STABLE_CYCLES);
            state    <= HOLD;
            cap_pend <= 1'b1;
            cap_idx  <= sample[9:8];
            cap_seg  <= sample[7:0];
          end else begin
            stab_cnt <= stab_cnt + SW'(1);
          end
        end
        HOLD: begin
          if (!an_ok) begin
            stab_cnt <= '0;
            state    <= IDLE;
          end else if (cur != sample) begin
            sample   <= cur;
            stab_cnt <= SW'(1);
            state    <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digits      <= 16'h0000;
      dp          <= 4'h0;
      seg_err     <= 4'h0;
      seen        <= 4'h0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (cap_pend) begin
        digits[{cap_idx, 2'b00} +: 4] <= dec[3:0];
        dp[cap_idx]      <= ~cap_seg[7];
        seg_err[cap_idx] <= dec[4];
        if ((seen | cap_bit) == 4'hF) begin
          frame_valid <= 1'b1;
          seen        <= 4'h0;
        end else begin
          seen <= seen | cap_bit;
        end
      end
      // A lost scan discards the partial frame; decoded values stay visible.
      if (timeout_hit) seen <= 4'h0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt  <= '0;
      scan_lost <= 1'b0;
    end else if (an_ok) begin
      idle_cnt  <= '0;
      scan_lost <= 1'b0;
    end else if (idle_cnt < TW'(TIMEOUT_CYCLES)) begin
      idle_cnt <= idle_cnt + TW'(1);
      if (timeout_hit) scan_lost <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: drives scanned anode/segment patterns and checks the
// decoded digits, decimal points, glyph errors, frame pulses and scan-loss timeout.
module tb_sseg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  seg_err;
  logic        frame_valid;
  logic        scan_lost;
  logic [1:0]  fsm_state;

  int vec_cnt = 0;
  int err_cnt = 0;
  int fv_cnt  = 0;
  int fv_base;

  sseg_scan_decoder #(.STABLE_CYCLES(16), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .reset(reset), .an(an), .sseg(sseg), .digits(digits), .dp(dp),
    .seg_err(seg_err), .frame_valid(frame_valid), .scan_lost(scan_lost), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_valid === 1'b1) fv_cnt <= fv_cnt + 1;

  // Active-low segment byte for a hex code, decimal point off.
  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 8'hC0; 4'h1: glyph = 8'hF9; 4'h2: glyph = 8'hA4; 4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99; 4'h5: glyph = 8'h92; 4'h6: glyph = 8'h82; 4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80; 4'h9: glyph = 8'h90; 4'hA: glyph = 8'h88; 4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6; 4'hD: glyph = 8'hA1; 4'hE: glyph = 8'h86; default: glyph = 8'h8E;
    endcase
  endfunction

  // Called at a negedge; returns at a negedge after n rising edges.
  task automatic drive_digit(input int idx, input logic [7:0] s, input int n);
    an = 4'hF;
    an[idx] = 1'b0;
    sseg = s;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_raw(input logic [3:0] a, input logic [7:0] s, input int n);
    an = a;
    sseg = s;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    an = 4'hF;
    sseg = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    an = 4'hF;
    sseg = 8'hFF;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec_cnt++; if (digits !== 16'h0) begin err_cnt++; $display("FAIL rst_digits: got %h want 0000", digits); end
    vec_cnt++; if ({dp, seg_err} !== 8'h00) begin err_cnt++; $display("FAIL rst_dp_err: got %b %b want 0", dp, seg_err); end
    vec_cnt++; if ({frame_valid, scan_lost} !== 2'b00) begin err_cnt++; $display("FAIL rst_flags: got %b%b want 00", frame_valid, scan_lost); end
    vec_cnt++; if (fsm_state !== 2'd0) begin err_cnt++; $display("FAIL rst_state: got %0d want 0", fsm_state); end
    reset = 1'b1;
  endtask

  task automatic test_latency();
    drive_digit(0, glyph(4'hA), 18);
    vec_cnt++; if (digits !== 16'h0000) begin err_cnt++; $display("FAIL lat_early: got %h want 0000", digits); end
    drive_digit(0, glyph(4'hA), 1);
    vec_cnt++; if (digits !== 16'h000A) begin err_cnt++; $display("FAIL lat_update: got %h want 000A", digits); end
    vec_cnt++; if (fsm_state !== 2'd2) begin err_cnt++; $display("FAIL lat_hold: got %0d want 2", fsm_state); end
    drive_digit(0, glyph(4'hA), 80);
  endtask

  task automatic test_scan();
    fv_base = fv_cnt;
    for (int k = 0; k < 2; k++) begin
      drive_digit(0, glyph(4'h4), 100);
      drive_digit(1, glyph(4'h3), 100);
      drive_digit(2, glyph(4'h2) & 8'h7F, 100);
      drive_digit(3, glyph(4'h1), 100);
    end
    vec_cnt++; if (digits !== 16'h1234) begin err_cnt++; $display("FAIL scan_digits: got %h want 1234", digits); end
    vec_cnt++; if (dp !== 4'b0100) begin err_cnt++; $display("FAIL scan_dp: got %b want 0100", dp); end
    vec_cnt++; if (seg_err !== 4'b0000) begin err_cnt++; $display("FAIL scan_err: got %b want 0000", seg_err); end
    vec_cnt++; if (fv_cnt - fv_base !== 2) begin err_cnt++; $display("FAIL scan_frames: got %0d want 2", fv_cnt - fv_base); end
    vec_cnt++; if (scan_lost !== 1'b0) begin err_cnt++; $display("FAIL scan_lost_lvl: got %b want 0", scan_lost); end
  endtask

  task automatic test_unstable();
    do_reset();
    fv_base = fv_cnt;
    for (int k = 0; k < 12; k++) drive_digit(0, (k % 2 == 0) ? glyph(4'h5) : glyph(4'h6), 8);
    vec_cnt++; if (digits !== 16'h0000) begin err_cnt++; $display("FAIL unstable_digits: got %h want 0000", digits); end
    vec_cnt++; if (fsm_state !== 2'd1) begin err_cnt++; $display("FAIL unstable_state: got %0d want 1", fsm_state); end
    vec_cnt++; if (fv_cnt !== fv_base) begin err_cnt++; $display("FAIL unstable_frames: got %0d want %0d", fv_cnt, fv_base); end
  endtask

  task automatic test_multi_anode();
    fv_base = fv_cnt;
    drive_raw(4'b1100, glyph(4'h8), 50);
    vec_cnt++; if (fsm_state !== 2'd0) begin err_cnt++; $display("FAIL multi_state: got %0d want 0", fsm_state); end
    vec_cnt++; if (digits !== 16'h0000) begin err_cnt++; $display("FAIL multi_digits: got %h want 0000", digits); end
    drive_digit(0, glyph(4'h7), 100);
    drive_digit(1, glyph(4'hC), 100);
    drive_digit(2, glyph(4'h5), 100);
    drive_digit(3, glyph(4'hA), 100);
    vec_cnt++; if (digits !== 16'hA5C7) begin err_cnt++; $display("FAIL multi_resume: got %h want A5C7", digits); end
    vec_cnt++; if (fv_cnt - fv_base !== 1) begin err_cnt++; $display("FAIL multi_frames: got %0d want 1", fv_cnt - fv_base); end
  endtask

  task automatic test_timeout();
    drive_digit(0, glyph(4'h1), 100);
    drive_digit(1, glyph(4'h2), 100);
    fv_base = fv_cnt;
    drive_raw(4'hF, 8'hFF, 1001);
    vec_cnt++; if (scan_lost !== 1'b0) begin err_cnt++; $display("FAIL to_early: got %b want 0", scan_lost); end
    drive_raw(4'hF, 8'hFF, 1);
    vec_cnt++; if (scan_lost !== 1'b1) begin err_cnt++; $display("FAIL to_assert: got %b want 1", scan_lost); end
    vec_cnt++; if (digits !== 16'hA521) begin err_cnt++; $display("FAIL to_retain: got %h want A521", digits); end
    drive_digit(3, glyph(4'h3), 2);
    vec_cnt++; if (scan_lost !== 1'b1) begin err_cnt++; $display("FAIL to_hold: got %b want 1", scan_lost); end
    drive_digit(3, glyph(4'h3), 1);
    vec_cnt++; if (scan_lost !== 1'b0) begin err_cnt++; $display("FAIL to_clear: got %b want 0", scan_lost); end
    drive_digit(3, glyph(4'h3), 97);
    drive_digit(2, glyph(4'h4), 100);
    drive_digit(1, glyph(4'h5), 100);
    vec_cnt++; if (fv_cnt !== fv_base) begin err_cnt++; $display("FAIL to_partial: got %0d want %0d", fv_cnt, fv_base); end
    drive_digit(0, glyph(4'h6), 100);
    vec_cnt++; if (fv_cnt - fv_base !== 1) begin err_cnt++; $display("FAIL to_frame: got %0d want 1", fv_cnt - fv_base); end
    vec_cnt++; if (digits !== 16'h3456) begin err_cnt++; $display("FAIL to_digits: got %h want 3456", digits); end
  endtask

  task automatic test_bad_glyph();
    drive_digit(0, glyph(4'h9), 100);
    drive_digit(1, 8'hFF, 100);
    drive_digit(2, 8'hF6, 100);
    drive_digit(3, glyph(4'hE), 100);
    vec_cnt++; if (digits !== 16'hEF09) begin err_cnt++; $display("FAIL bad_digits: got %h want EF09", digits); end
    vec_cnt++; if (seg_err !== 4'b0110) begin err_cnt++; $display("FAIL bad_err: got %b want 0110", seg_err); end
    vec_cnt++; if (dp !== 4'b0000) begin err_cnt++; $display("FAIL bad_dp: got %b want 0000", dp); end
  endtask

  task automatic test_reset_mid();
    drive_digit(0, glyph(4'h7), 100);
    drive_digit(1, glyph(4'h8), 100);
    drive_digit(2, glyph(4'h9), 10);
    reset = 1'b0;
    #1;
    vec_cnt++; if (digits !== 16'h0000) begin err_cnt++; $display("FAIL mid_digits: got %h want 0000", digits); end
    vec_cnt++; if ({dp, seg_err, scan_lost} !== 9'h000) begin err_cnt++; $display("FAIL mid_flags: got %b %b %b want 0", dp, seg_err, scan_lost); end
    vec_cnt++; if (fsm_state !== 2'd0) begin err_cnt++; $display("FAIL mid_state: got %0d want 0", fsm_state); end
    @(negedge clk);
    reset = 1'b1;
    fv_base = fv_cnt;
    drive_digit(2, glyph(4'h9), 100);
    drive_digit(3, glyph(4'h1), 100);
    drive_digit(0, glyph(4'h7), 100);
    vec_cnt++; if (fv_cnt !== fv_base) begin err_cnt++; $display("FAIL mid_partial: got %0d want %0d", fv_cnt, fv_base); end
    drive_digit(1, glyph(4'h8), 100);
    vec_cnt++; if (fv_cnt - fv_base !== 1) begin err_cnt++; $display("FAIL mid_frame: got %0d want 1", fv_cnt - fv_base); end
    vec_cnt++; if (digits !== 16'h1987) begin err_cnt++; $display("FAIL mid_digits_after: got %h want 1987", digits); end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_latency();
    test_scan();
    test_unstable();
    test_multi_anode();
    test_timeout();
    test_bad_glyph();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
